fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 14 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 86 ++++++++
 tb/tb_fetch_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch path.
// Default widths, reset PC and the buffered fetch-entry layout.
package fetch_pkg;

    localparam int FQ_AW       = 16;
    localparam int FQ_IW       = 16;
    localparam int FQ_RESET_PC = 0;

    typedef struct packed {
        logic [FQ_AW-1:0] addr;
        logic [FQ_IW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and flush.
// Flush wins over push/pop; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch queue with credit-limited issue.
// Redirects flush buffered entries and drop responses still in flight.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int AW       = FQ_AW,
    parameter int IW       = FQ_IW,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = FQ_RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ib_push,
    output logic [AW+IW-1:0] ib_push_data,
    input  logic          ib_full,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic          mem_ready,
    input  logic [AW-1:0] mem_addr_out,
    input  logic [IW-1:0] mem_data_out,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          issue;

    assign used      = {1'b0, out_cnt} + {1'b0, count};
    assign issue     = !rst && !branch_taken
                       && (used < (CW+1)'(DEPTH));
    assign mem_re    = issue;
    assign mem_raddr = pc;

    assign fifo_push = mem_ready && (drop_cnt == '0)
                       && !branch_taken && !fifo_full;
    assign ib_push   = !rst && !ib_full && !fifo_empty
                       && !branch_taken;

    sync_fifo #(
        .W     (AW + IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_taken),
        .push      (fifo_push),
        .push_data ({mem_addr_out, mem_data_out}),
        .pop       (ib_push),
        .pop_data  (ib_push_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // Fetch PC, in-flight request count and stale-response count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= AW'(RESET_PC);
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(issue) - CW'(mem_ready);
            if (branch_taken) begin
                pc       <= branch_target;
                drop_cnt <= out_cnt - CW'(mem_ready);
            end else begin
                if (issue) begin
                    pc <= pc + AW'(1);
                end
                if (mem_ready && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against an epoch-tagged queue model.
// Memory model returns responses in order with configurable latency.
module tb_fetch_queue;

    localparam int AW       = 16;
    localparam int IW       = 16;
    localparam int DEPTH    = 4;
    localparam int RESET_PC = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          ib_push;
    logic [AW+IW-1:0] ib_push_data;
    logic          ib_full;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic          mem_ready;
    logic [AW-1:0] mem_addr_out;
    logic [IW-1:0] mem_data_out;
    logic          branch_taken;
    logic [AW-1:0] branch_target;

    fetch_queue #(
        .AW       (AW),
        .IW       (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ib_push       (ib_push),
        .ib_push_data  (ib_push_data),
        .ib_full       (ib_full),
        .mem_re        (mem_re),
        .mem_raddr     (mem_raddr),
        .mem_ready     (mem_ready),
        .mem_addr_out  (mem_addr_out),
        .mem_data_out  (mem_data_out),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            ep;
        int            due;
    } req_t;

    req_t          mq[$];
    logic [AW-1:0] fq[$];
    logic [AW-1:0] m_pc;
    int            epoch;
    int            cyc;
    int            lat_min;
    int            lat_max;
    int            n_cmp;
    int            n_bad;

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
        return IW'(a * 16'h9E37) ^ IW'(16'h5A5A);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input logic bt, input logic [AW-1:0] tgt,
                         input logic full);
        logic resp;
        logic e_re;
        logic e_push;
        req_t r;
        branch_taken  = bt;
        branch_target = tgt;
        ib_full       = full;
        resp = (mq.size() > 0) && (mq[0].due <= cyc);
        mem_ready = resp;
        if (resp) begin
            mem_addr_out = mq[0].addr;
            mem_data_out = instr_of(mq[0].addr);
        end else begin
            mem_addr_out = $urandom();
            mem_data_out = $urandom();
        end
        e_re   = !bt && ((mq.size() + fq.size()) < DEPTH);
        e_push = !full && (fq.size() > 0) && !bt;
        #4;
        chk("mem_re", 64'(mem_re), 64'(e_re));
        if (e_re) chk("mem_raddr", 64'(mem_raddr), 64'(m_pc));
        chk("ib_push", 64'(ib_push), 64'(e_push));
        if (e_push)
            chk("push_data", 64'(ib_push_data),
                64'({fq[0], instr_of(fq[0])}));
        @(posedge clk);
        if (e_push) void'(fq.pop_front());
        if (resp) begin
            r = mq.pop_front();
            if (!bt && r.ep == epoch) fq.push_back(r.addr);
        end
        if (bt) begin
            fq.delete();
            epoch++;
            m_pc = tgt;
        end
        if (e_re) begin
            r.addr = m_pc;
            r.ep   = epoch;
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            mq.push_back(r);
            m_pc = m_pc + AW'(1);
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n, input int full_pct, input int br_pct);
        for (int i = 0; i < n; i++) begin
            cycle(($urandom_range(99) < br_pct), AW'($urandom()),
                  ($urandom_range(99) < full_pct));
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        chk("rst_async_re", 64'(mem_re), 64'(0));
        chk("rst_async_push", 64'(ib_push), 64'(0));
        mq.delete();
        fq.delete();
        epoch++;
        m_pc = AW'(RESET_PC);
        for (int i = 0; i < n; i++) begin
            mem_ready    = 1'b1;
            mem_addr_out = $urandom();
            mem_data_out = $urandom();
            #2;
            chk("rst_re", 64'(mem_re), 64'(0));
            chk("rst_push", 64'(ib_push), 64'(0));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        epoch = 0;
        lat_min = 1;
        lat_max = 1;
        m_pc = AW'(RESET_PC);
        rst = 1'b1;
        ib_full = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        mem_ready = 1'b0;
        mem_addr_out = '0;
        mem_data_out = '0;
        @(posedge clk);
        #1;
        do_reset(3);

        run(20, 0, 0);

        lat_min = 3;
        lat_max = 3;
        run(30, 0, 0);

        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        run(8, 0, 0);

        lat_min = 3;
        lat_max = 3;
        k = 0;
        while (mq.size() != 2 && k < 20) begin
            cycle(1'b0, '0, 1'b0);
            k++;
        end
        chk("wait_out2", 64'(mq.size()), 64'(2));
        cycle(1'b1, 16'h0040, 1'b0);
        run(15, 0, 0);

        lat_min = 1;
        lat_max = 1;
        run(6, 0, 0);
        cycle(1'b1, 16'h1234, 1'b0);
        run(8, 0, 0);

        lat_min = 3;
        lat_max = 3;
        run(6, 0, 0);
        cycle(1'b1, 16'h0200, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 16'h0300, 1'b0);
        run(12, 0, 0);

        lat_min = 1;
        lat_max = 1;
        cycle(1'b1, 16'hFFFE, 1'b0);
        run(10, 0, 0);
        do_reset(2);
        run(10, 0, 0);

        lat_min = 1;
        lat_max = 4;
        run(300, 25, 5);
        do_reset(1);
        run(300, 40, 8);

        lat_min = 1;
        lat_max = 1;
        run(20, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
